// File: rtl/nw_fill_controller.sv
// nw_fill_controller: top-level sequencer for the Needleman-Wunsch score-matrix
// engine. It steps the signal-manager datapath through first-row/column
// initialization and then the per-cell read / wait-for-max / insert / advance
// loop until the matrix is full. It reports progress, completion and a
// calculation timeout to the system FSM.
module nw_fill_controller #(
  parameter int N            = 128,
  parameter int BitAddr      = $clog2(N + 1),
  parameter int CALC_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   end_init,
  input  logic                   calculated,
  input  logic                   hit_4,
  input  logic                   end_filling,
  output logic                   en_init,
  output logic                   en_read,
  output logic                   en_ins,
  output logic                   change_index,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             state,
  output logic [2*BitAddr-1:0]   cell_count
);

  localparam int CW = 2 * BitAddr;
  // Wide enough to hold CALC_TIMEOUT itself, which the timer can reach on the
  // cycle it leaves WAIT_CALC with a late result.
  localparam int TW = $clog2(CALC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    READ      = 3'd2,
    WAIT_CALC = 3'd3,
    INSERT    = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  count_q;
  logic           timed_out;

  assign timed_out = (timer == TW'(CALC_TIMEOUT - 1));

  // State register; reset puts the sequencer back in IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition, and inputs
  // unrelated to the current state are ignored.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: if (start) state_d = INIT;
        INIT:              if (end_init) state_d = READ;
        READ:              state_d = WAIT_CALC;
        WAIT_CALC: begin
          if (calculated) begin
            state_d = INSERT;
          end else if (timed_out) begin
            state_d = ERROR;
          end
        end
        INSERT:            if (hit_4) state_d = NEXT;
        NEXT:              state_d = end_filling ? DONE : READ;
        default:           state_d = IDLE;
      endcase
    end
  end

  // WAIT_CALC watchdog; WAIT_CALC is only ever entered from READ, so clearing
  // in READ gives a fresh count on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_q == READ) begin
      timer <= '0;
    end else if (state_q == WAIT_CALC) begin
      timer <= timer + 1'b1;
    end
  end

  // Cells completed this run: cleared when a new run enters INIT, bumped once
  // per NEXT, saturating at all-ones, and left alone by abort and ERROR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (state_d == INIT && state_q != INIT) begin
      count_q <= '0;
    end else if (state_q == NEXT && !abort && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign en_init      = (state_q == INIT);
  assign en_read      = (state_q == READ);
  assign en_ins       = (state_q == INSERT);
  assign change_index = (state_q == NEXT);
  assign busy         = (state_q == INIT) || (state_q == READ) ||
                        (state_q == WAIT_CALC) || (state_q == INSERT) ||
                        (state_q == NEXT);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign state        = state_q;
  assign cell_count   = count_q;

endmodule
